// File: rtl/uart_cmd_parser_if.sv
// Byte-stream handshake from the UART receiver plus the character/colour buffer write port.
interface uart_cmd_parser_if #(
    parameter int unsigned IDX_W = 3
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [7:0]       wr_char;
    logic [3:0]       wr_color;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_char, wr_color
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_char, wr_color
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Turns received bytes into character/colour buffer writes at a wrapping cursor,
// with CR/BS control bytes and ESC sequences for home, clear and colour selection.
module uart_cmd_parser #(
    parameter int unsigned MAX_CHARS = 8,
    parameter int unsigned IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] num_chars,
    input  logic [3:0]       rnd_color,
    uart_cmd_parser_if.slave bus,
    output logic [IDX_W-1:0] cursor,
    output logic             fixed_mode,
    output logic             err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_CHARS - 1);

    localparam logic [7:0] B_BS  = 8'h08;
    localparam logic [7:0] B_CR  = 8'h0D;
    localparam logic [7:0] B_ESC = 8'h1B;
    localparam logic [7:0] B_C   = 8'h43;
    localparam logic [7:0] B_H   = 8'h48;
    localparam logic [7:0] B_R   = 8'h52;
    localparam logic [7:0] B_X   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ESC   = 2'd1,
        ST_COLOR = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cursor_q, cursor_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             fixed_mode_q, fixed_mode_d;
    logic [3:0]       fixed_color_q, fixed_color_d;
    logic             wr_en_q, wr_en_d;
    logic [IDX_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_char_q, wr_char_d;
    logic [3:0]       wr_color_q, wr_color_d;
    logic             err_q, err_d;

    logic             accept;
    logic [IDX_W-1:0] cursor_adv;
    logic [3:0]       color_sel;
    logic [4:0]       hex;

    // Returns {valid, value} for an ASCII hex digit in either case.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [4:0] r;
        r = '0;
        if (b >= 8'h30 && b <= 8'h39)      r = {1'b1, 4'(b - 8'h30)};
        else if (b >= 8'h41 && b <= 8'h46) r = {1'b1, 4'(b - 8'h37)};
        else if (b >= 8'h61 && b <= 8'h66) r = {1'b1, 4'(b - 8'h57)};
        return r;
    endfunction

    assign bus.rx_ready = (state_q != ST_CLEAR);
    assign accept       = bus.rx_valid & bus.rx_ready;
    assign cursor_adv   = (cursor_q >= num_chars) ? '0 : cursor_q + IDX_W'(1);
    assign color_sel    = fixed_mode_q ? fixed_color_q : rnd_color;
    assign hex          = hex_decode(bus.rx_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cursor_q      <= '0;
            clr_idx_q     <= '0;
            fixed_mode_q  <= 1'b0;
            fixed_color_q <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_char_q     <= '0;
            wr_color_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            clr_idx_q     <= clr_idx_d;
            fixed_mode_q  <= fixed_mode_d;
            fixed_color_q <= fixed_color_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_char_q     <= wr_char_d;
            wr_color_q    <= wr_color_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        clr_idx_d     = clr_idx_q;
        fixed_mode_d  = fixed_mode_q;
        fixed_color_d = fixed_color_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_char_d     = wr_char_q;
        wr_color_d    = wr_color_q;
        err_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.rx_data >= 8'h20 && bus.rx_data <= 8'h7E) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = cursor_q;
                        wr_char_d  = bus.rx_data;
                        wr_color_d = color_sel;
                        cursor_d   = cursor_adv;
                    end else if (bus.rx_data == B_CR) begin
                        cursor_d = '0;
                    end else if (bus.rx_data == B_BS) begin
                        cursor_d = (cursor_q == '0) ? num_chars : cursor_q - IDX_W'(1);
                    end else if (bus.rx_data == B_ESC) begin
                        state_d = ST_ESC;
                    end
                end
            end
            ST_ESC: begin
                if (accept) begin
                    state_d = ST_IDLE;
                    case (bus.rx_data)
                        B_C:     state_d = ST_COLOR;
                        B_R:     fixed_mode_d = 1'b0;
                        B_H:     cursor_d = '0;
                        B_X: begin
                            clr_idx_d = '0;
                            state_d   = ST_CLEAR;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_COLOR: begin
                if (accept) begin
                    state_d = ST_IDLE;
                    if (hex[4]) begin
                        fixed_color_d = hex[3:0];
                        fixed_mode_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                // Blank every entry, one per cycle, independent of num_chars.
                wr_en_d    = 1'b1;
                wr_addr_d  = clr_idx_q;
                wr_char_d  = 8'h00;
                wr_color_d = 4'h0;
                clr_idx_d  = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == LAST_IDX) begin
                    cursor_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_char  = wr_char_q;
    assign bus.wr_color = wr_color_q;
    assign cursor       = cursor_q;
    assign fixed_mode   = fixed_mode_q;
    assign err          = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed vector table, hand-written
// clear/reset sequences, then random bytes against a behavioural model.
module tb_uart_cmd_parser;

    localparam int unsigned MAX_CHARS = 8;
    localparam int unsigned IDX_W     = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [IDX_W-1:0] num_chars;
    logic [3:0]       rnd_color;
    logic [IDX_W-1:0] cursor;
    logic             fixed_mode;
    logic             err;

    uart_cmd_parser_if #(.IDX_W(IDX_W)) bus ();

    uart_cmd_parser #(.MAX_CHARS(MAX_CHARS), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .num_chars  (num_chars),
        .rnd_color  (rnd_color),
        .bus        (bus),
        .cursor     (cursor),
        .fixed_mode (fixed_mode),
        .err        (err)
    );

    always #25 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [IDX_W-1:0] nc,
                         input logic [3:0] rc);
        bus.rx_valid = v;
        bus.rx_data  = d;
        num_chars    = nc;
        rnd_color    = rc;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Directed vectors: one accepted byte each, expected state one cycle later.
    typedef struct {
        logic [7:0]       data;
        logic [IDX_W-1:0] nc;
        logic [3:0]       rc;
        logic             wr;
        logic [IDX_W-1:0] addr;
        logic [3:0]       col;
        logic             er;
        logic [IDX_W-1:0] cur;
        logic             fm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] d, input int nc, input int rc, input logic wr,
                       input int a, input int col, input logic er, input int cur,
                       input logic fm);
        vec_t v;
        v.data = d;
        v.nc   = IDX_W'(nc);
        v.rc   = 4'(rc);
        v.wr   = wr;
        v.addr = IDX_W'(a);
        v.col  = 4'(col);
        v.er   = er;
        v.cur  = IDX_W'(cur);
        v.fm   = fm;
        tbl.push_back(v);
    endtask

    // Behavioural reference model
    int         m_cursor, m_fc, m_mode, m_clear_left, m_addr, m_col;
    logic       m_fm, m_wr, m_err;
    logic [7:0] m_ch;

    function automatic void model_reset();
        m_cursor = 0; m_fc = 0; m_mode = 0; m_clear_left = 0;
        m_fm = 1'b0; m_wr = 1'b0; m_err = 1'b0;
        m_addr = 0; m_ch = 8'h00; m_col = 0;
    endfunction

    function automatic void model_edge(input logic v, input logic [7:0] d, input int nc,
                                       input int rc);
        int val;
        m_wr  = 1'b0;
        m_err = 1'b0;
        if (m_clear_left > 0) begin
            m_wr   = 1'b1;
            m_addr = int'(MAX_CHARS) - m_clear_left;
            m_ch   = 8'h00;
            m_col  = 0;
            m_clear_left--;
            if (m_clear_left == 0) m_cursor = 0;
            return;
        end
        if (!v) return;
        if (m_mode == 0) begin
            if (d >= 8'h20 && d <= 8'h7E) begin
                m_wr     = 1'b1;
                m_addr   = m_cursor;
                m_ch     = d;
                m_col    = m_fm ? m_fc : rc;
                m_cursor = (m_cursor >= nc) ? 0 : m_cursor + 1;
            end else if (d == 8'h0D) m_cursor = 0;
            else if (d == 8'h08) m_cursor = (m_cursor == 0) ? nc : m_cursor - 1;
            else if (d == 8'h1B) m_mode = 1;
        end else if (m_mode == 1) begin
            m_mode = 0;
            if (d == "C") m_mode = 2;
            else if (d == "R") m_fm = 1'b0;
            else if (d == "H") m_cursor = 0;
            else if (d == "X") m_clear_left = int'(MAX_CHARS);
            else m_err = 1'b1;
        end else begin
            m_mode = 0;
            val = -1;
            if (d >= "0" && d <= "9") val = int'(d) - 48;
            else if (d >= "A" && d <= "F") val = int'(d) - 55;
            else if (d >= "a" && d <= "f") val = int'(d) - 87;
            if (val >= 0) begin
                m_fm = 1'b1;
                m_fc = val;
            end else m_err = 1'b1;
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, IDX_W'(7), 4'd0);
        #1;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_rx_ready", bus.rx_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic send(input logic [7:0] d);
        drive(1'b1, d, IDX_W'(7), 4'd0);
        tick();
    endtask

    initial begin
        byte        b;
        logic       v;
        int         nc_r, rc_r, sel;
        string      cmds = "CRHXQ";
        string      hexs = "0123456789abcdefABCDEFgG";

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        num_chars    = IDX_W'(7);
        rnd_color    = 4'd0;
        rst_n        = 1'b0;
        @(negedge clk);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_char", bus.wr_char, 0);
        chk("rst_wr_color", bus.wr_color, 0);
        chk("rst_fixed_mode", fixed_mode, 0);
        chk("rst_err", err, 0);
        do_reset();

        // d, nc, rc, wr, addr, col, err, cursor, fixed_mode
        add(8'h41, 7, 5, 1, 0, 5, 0, 1, 0);
        add(8'h42, 7, 5, 1, 1, 5, 0, 2, 0);
        add(8'h0D, 7, 5, 0, 0, 0, 0, 0, 0);
        add(8'h61, 2, 3, 1, 0, 3, 0, 1, 0);
        add(8'h62, 2, 3, 1, 1, 3, 0, 2, 0);
        add(8'h63, 2, 3, 1, 2, 3, 0, 0, 0);
        add(8'h64, 2, 3, 1, 0, 3, 0, 1, 0);
        add(8'h1B, 2, 3, 0, 0, 0, 0, 1, 0);
        add(8'h43, 2, 3, 0, 0, 0, 0, 1, 0);
        add(8'h61, 2, 3, 0, 0, 0, 0, 1, 1);
        add(8'h5A, 2, 3, 1, 1, 10, 0, 2, 1);
        add(8'h1B, 2, 3, 0, 0, 0, 0, 2, 1);
        add(8'h52, 2, 3, 0, 0, 0, 0, 2, 0);
        add(8'h59, 2, 6, 1, 2, 6, 0, 0, 0);
        add(8'h08, 5, 6, 0, 0, 0, 0, 5, 0);
        add(8'h0D, 5, 6, 0, 0, 0, 0, 0, 0);
        add(8'h1B, 5, 6, 0, 0, 0, 0, 0, 0);
        add(8'h51, 5, 6, 0, 0, 0, 1, 0, 0);
        add(8'h1B, 5, 6, 0, 0, 0, 0, 0, 0);
        add(8'h1B, 5, 6, 0, 0, 0, 1, 0, 0);
        add(8'h1B, 5, 6, 0, 0, 0, 0, 0, 0);
        add(8'h43, 5, 6, 0, 0, 0, 0, 0, 0);
        add(8'h67, 5, 6, 0, 0, 0, 1, 0, 0);
        add(8'h1B, 5, 6, 0, 0, 0, 0, 0, 0);
        add(8'h43, 5, 6, 0, 0, 0, 0, 0, 0);
        add(8'h37, 5, 6, 0, 0, 0, 0, 0, 1);
        add(8'h1B, 5, 6, 0, 0, 0, 0, 0, 1);
        add(8'h43, 5, 6, 0, 0, 0, 0, 0, 1);
        add(8'h67, 5, 6, 0, 0, 0, 1, 0, 1);
        add(8'h6B, 5, 9, 1, 0, 7, 0, 1, 1);
        add(8'h01, 5, 9, 0, 0, 0, 0, 1, 1);
        add(8'h1B, 5, 9, 0, 0, 0, 0, 1, 1);
        add(8'h48, 5, 9, 0, 0, 0, 0, 0, 1);
        add(8'h78, 5, 9, 1, 0, 7, 0, 1, 1);
        add(8'h79, 5, 9, 1, 1, 7, 0, 2, 1);
        add(8'h77, 5, 9, 1, 2, 7, 0, 3, 1);
        add(8'h7A, 1, 9, 1, 3, 7, 0, 0, 1);
        add(8'h1B, 1, 9, 0, 0, 0, 0, 0, 1);
        add(8'h52, 1, 9, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            chk($sformatf("v%0d_rx_ready", i), bus.rx_ready, 1);
            drive(1'b1, tbl[i].data, tbl[i].nc, tbl[i].rc);
            tick();
            chk($sformatf("v%0d_wr_en", i), bus.wr_en, tbl[i].wr);
            if (tbl[i].wr) begin
                chk($sformatf("v%0d_wr_addr", i), bus.wr_addr, tbl[i].addr);
                chk($sformatf("v%0d_wr_char", i), bus.wr_char, tbl[i].data);
                chk($sformatf("v%0d_wr_color", i), bus.wr_color, tbl[i].col);
            end
            chk($sformatf("v%0d_err", i), err, tbl[i].er);
            chk($sformatf("v%0d_cursor", i), cursor, tbl[i].cur);
            chk($sformatf("v%0d_fixed_mode", i), fixed_mode, tbl[i].fm);
        end

        // Clear with rx_valid held: 8 stalled cycles, 8 writes, then the held byte lands.
        send(8'h41);
        send(8'h1B);
        send(8'h58);
        chk("clr_first_wr_en", bus.wr_en, 0);
        drive(1'b1, 8'h57, IDX_W'(7), 4'd4);
        for (int i = 0; i < int'(MAX_CHARS); i++) begin
            chk($sformatf("clr%0d_rx_ready", i), bus.rx_ready, 0);
            tick();
            chk($sformatf("clr%0d_wr_en", i), bus.wr_en, 1);
            chk($sformatf("clr%0d_wr_addr", i), bus.wr_addr, i);
            chk($sformatf("clr%0d_wr_char", i), bus.wr_char, 0);
            chk($sformatf("clr%0d_wr_color", i), bus.wr_color, 0);
        end
        chk("clr_done_cursor", cursor, 0);
        chk("clr_done_rx_ready", bus.rx_ready, 1);
        tick();
        chk("post_clr_wr_en", bus.wr_en, 1);
        chk("post_clr_wr_addr", bus.wr_addr, 0);
        chk("post_clr_wr_char", bus.wr_char, 8'h57);
        chk("post_clr_wr_color", bus.wr_color, 4);
        chk("post_clr_cursor", cursor, 1);
        drive(1'b0, 8'h00, IDX_W'(7), 4'd0);
        tick();
        chk("post_clr_idle_wr_en", bus.wr_en, 0);

        // Reset in the middle of a clear: writes stop immediately and do not resume.
        send(8'h1B);
        send(8'h43);
        send(8'h35);
        send(8'h1B);
        send(8'h58);
        drive(1'b0, 8'h00, IDX_W'(7), 4'd0);
        tick();
        tick();
        chk("midclr_wr_en", bus.wr_en, 1);
        rst_n = 1'b0;
        #1;
        chk("midclr_rst_wr_en", bus.wr_en, 0);
        chk("midclr_rst_cursor", cursor, 0);
        chk("midclr_rst_fixed_mode", fixed_mode, 0);
        chk("midclr_rst_rx_ready", bus.rx_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("midclr_after%0d_wr_en", i), bus.wr_en, 0);
            chk($sformatf("midclr_after%0d_rx_ready", i), bus.rx_ready, 1);
        end

        // Random byte stream against the model.
        do_reset();
        nc_r = 7;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 49) == 0) nc_r = int'($urandom_range(0, MAX_CHARS - 1));
            rc_r = int'($urandom_range(0, 15));
            v    = ($urandom_range(0, 3) != 0);
            sel  = int'($urandom_range(0, 15));
            case (sel)
                6, 7:    b = 8'h1B;
                8:       b = cmds[$urandom_range(0, 4)];
                9:       b = hexs[$urandom_range(0, 23)];
                10:      b = 8'h0D;
                11:      b = 8'h08;
                12:      b = 8'($urandom_range(0, 255));
                default: b = 8'($urandom_range(32, 126));
            endcase
            chk("rnd_rx_ready", bus.rx_ready, (m_clear_left == 0) ? 1 : 0);
            drive(v, b, IDX_W'(nc_r), 4'(rc_r));
            @(posedge clk);
            model_edge(v, b, nc_r, rc_r);
            @(negedge clk);
            chk("rnd_wr_en", bus.wr_en, m_wr);
            if (m_wr) begin
                chk("rnd_wr_addr", bus.wr_addr, m_addr);
                chk("rnd_wr_char", bus.wr_char, m_ch);
                chk("rnd_wr_color", bus.wr_color, m_col);
            end
            chk("rnd_err", err, m_err);
            chk("rnd_cursor", cursor, m_cursor);
            chk("rnd_fixed_mode", fixed_mode, m_fm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
